// File: rtl/audioplay_pio_pkg.sv
// Shared address map, field positions and helpers for the audio player PIO ports.
// Latency: n/a (constants only). Backpressure: n/a.
// Imported by the control-output port and its pulse timer.
package audioplay_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_OUTSET   = 2'd1;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
    localparam logic [1:0] ADDR_PULSE    = 2'd3;

    localparam int BUSY_BIT      = 31;
    localparam int PULSE_LEN_LSB = 16;
    localparam int PULSE_CNT_W   = 16;

    typedef logic [PULSE_CNT_W-1:0] pulse_cnt_t;

    // A zero-length request still produces a one-cycle strobe.
    function automatic pulse_cnt_t pulse_load_value(input pulse_cnt_t len);
        return (len == '0) ? pulse_cnt_t'(1) : len;
    endfunction

endpackage

// File: rtl/audioplay_pulse_timer.sv
// One-shot pulse down-counter: load/retrigger, cancel, one-cycle expire strobe.
// Latency: expire is combinational on the edge where the count reaches its end.
// Backpressure: none; load beats expiry, cancel clears immediately.
module audioplay_pulse_timer
    import audioplay_pio_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   cancel,
    input  logic [PULSE_CNT_W-1:0] len,
    output logic                   busy,
    output logic                   expire
);

    pulse_cnt_t cnt;

    // A retrigger or cancel on the final count suppresses the expiry.
    assign expire = busy && (cnt == pulse_cnt_t'(1)) && !load && !cancel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= pulse_load_value(len);
            busy <= 1'b1;
        end else if (cancel || expire) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (busy) begin
            cnt  <= cnt - pulse_cnt_t'(1);
        end
    end

endmodule

// File: rtl/audioplay_ctrl_out.sv
// Avalon-MM output port with set/clear aliases and optional timed pulse (AUDIOPLAY_CTRL_OUT_PULSE_EN).
// Latency: writes visible on out_port after the accepting edge; readdata one cycle after address.
// Backpressure: none; every write is accepted with zero wait states.
module audioplay_ctrl_out
    import audioplay_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] pulse_mask;
    logic [WIDTH-1:0] mask_d;
    logic             busy;
    logic             expire;
    logic [31:0]      data_word;
    logic [31:0]      pulse_word;
    logic             unused_bits;

    assign wr_en = chipselect && !write_n;
    assign wd    = writedata[WIDTH-1:0];

`ifdef AUDIOPLAY_CTRL_OUT_PULSE_EN
    localparam bit PULSE_EN = 1'b1;

    logic pulse_wr;
    logic data_wr;

    assign pulse_wr = wr_en && (address == ADDR_PULSE);
    assign data_wr  = wr_en && (address == ADDR_DATA);

    audioplay_pulse_timer u_pulse_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pulse_wr),
        .cancel  (data_wr),
        .len     (writedata[PULSE_LEN_LSB +: PULSE_CNT_W]),
        .busy    (busy),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_mask <= '0;
        end else begin
            pulse_mask <= mask_d;
        end
    end
`else
    localparam bit PULSE_EN = 1'b0;

    assign busy       = 1'b0;
    assign expire     = 1'b0;
    assign pulse_mask = '0;
`endif

    // Expiry is applied first so a same-edge OUTSET/OUTCLEAR lands on top of it.
    always_comb begin
        data_d = data_q;
        mask_d = pulse_mask;
        if (expire) begin
            data_d = data_q & ~pulse_mask;
            mask_d = '0;
        end
        if (wr_en) begin
            case (address)
                ADDR_DATA: begin
                    data_d = wd;
                    mask_d = '0;
                end
                ADDR_OUTSET:   data_d = data_d | wd;
                ADDR_OUTCLEAR: data_d = data_d & ~wd;
                ADDR_PULSE: begin
                    if (PULSE_EN) begin
                        data_d = data_d | wd;
                        mask_d = mask_d | wd;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_port   = data_q;
    assign data_word  = {{(32-WIDTH){1'b0}}, data_q};
    assign pulse_word = {busy, {(BUSY_BIT-WIDTH){1'b0}}, pulse_mask};

    // Read path samples pre-write state, so a same-edge write is not visible yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (address == ADDR_PULSE) begin
            readdata <= pulse_word;
        end else begin
            readdata <= data_word;
        end
    end

    assign unused_bits = ^{writedata, mask_d};

endmodule

// File: tb/tb_audioplay_ctrl_out.sv
// Self-checking bench for audioplay_ctrl_out: directed scenarios then random traffic vs a time-based model.
module tb_audioplay_ctrl_out;

`ifdef AUDIOPLAY_CTRL_OUT_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    // Reference state: pulse expiry is tracked as an absolute edge number.
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    bit          m_busy;
    int          m_cyc;
    int          m_exp;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    audioplay_ctrl_out #(
        .WIDTH       (8),
        .RESET_VALUE (8'h5A)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        if (a == 2'd3) begin
            return PULSE_EN ? {m_busy, 23'b0, m_mask} : 32'h0;
        end
        return {24'b0, m_data};
    endfunction

    task automatic model_reset();
        m_data = 8'h5A;
        m_mask = 8'h00;
        m_busy = 1'b0;
        m_cyc  = 0;
        m_exp  = 0;
        exp_rd = 32'h0;
    endtask

    task automatic model_edge();
        bit         wr = chipselect && !write_n;
        bit         pw = wr && (address == 2'd3) && PULSE_EN;
        bit         dw = wr && (address == 2'd0);
        logic [7:0] wm = writedata[7:0];
        int         len = int'(writedata[31:16]);
        if (len == 0) len = 1;
        if (m_busy && (m_cyc == m_exp) && !pw && !dw) begin
            m_data = m_data & ~m_mask;
            m_mask = 8'h00;
            m_busy = 1'b0;
        end
        if (wr) begin
            case (address)
                2'd0: begin
                    m_data = wm;
                    m_mask = 8'h00;
                    m_busy = 1'b0;
                end
                2'd1: m_data = m_data | wm;
                2'd2: m_data = m_data & ~wm;
                default: begin
                    if (PULSE_EN) begin
                        m_data = m_data | wm;
                        m_mask = m_mask | wm;
                        m_busy = 1'b1;
                        m_exp  = m_cyc + len;
                    end
                end
            endcase
        end
        m_cyc++;
    endtask

    task automatic tick();
        exp_rd = model_read(address);
        model_edge();
        @(posedge clk);
        #1;
        chk("out_port", 32'(out_port), 32'(m_data));
        chk("readdata", readdata, exp_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    initial begin
        int hi;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(out_port), 32'h5A);
        chk("rst_rd", readdata, 32'h0);
        reset_n = 1'b1;
        rd(2'd0);
        chk("rd_data", readdata, 32'h5A);

        wr(2'd0, 32'h0000_000F);
        chk("data_0f", 32'(out_port), 32'h0F);
        wr(2'd1, 32'h0000_00C0);
        chk("outset_cf", 32'(out_port), 32'hCF);
        wr(2'd2, 32'h0000_0003);
        chk("outclr_cc", 32'(out_port), 32'hCC);
        rd(2'd1);
        chk("rd_outset", readdata, 32'hCC);
        rd(2'd2);
        chk("rd_outclr", readdata, 32'hCC);

        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0005_0001);
        address = 2'd3;
        hi = out_port[0] ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 1) chk("busy_mid", 32'(readdata[31]), 32'(PULSE_EN));
            if (out_port[0]) hi++;
        end
        chk("pulse_len", 32'(hi), PULSE_EN ? 32'd5 : 32'd0);
        chk("busy_after", readdata, 32'h0);
        chk("pulse_done", 32'(out_port), 32'h0);

        wr(2'd3, 32'h0004_0001);
        tick();
        tick();
        wr(2'd3, 32'h0004_0002);
        chk("retrig_set", 32'(out_port), PULSE_EN ? 32'h03 : 32'h00);
        repeat (3) tick();
        chk("retrig_hold", 32'(out_port), PULSE_EN ? 32'h03 : 32'h00);
        tick();
        chk("retrig_clr", 32'(out_port), 32'h00);

        wr(2'd3, 32'h000A_0001);
        tick();
        wr(2'd0, 32'h0000_0080);
        chk("cancel_out", 32'(out_port), 32'h80);
        address = 2'd3;
        tick();
        chk("cancel_busy", readdata, 32'h0);
        repeat (12) tick();
        chk("cancel_hold", 32'(out_port), 32'h80);

        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0002_0001);
        tick();
        wr(2'd1, 32'h0000_0001);
        chk("exp_outset", 32'(out_port), 32'h01);
        address = 2'd3;
        tick();
        chk("exp_busy", readdata, 32'h0);

        wr(2'd3, 32'h0014_00F0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_port), 32'h5A);
        chk("arst_rd", readdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(2'd3);
        chk("arst_busy", readdata, 32'h0);

        wr(2'd0, 32'h0000_003C);
        wr(2'd3, 32'hFFFF_00FF);
        chk("pw_out", 32'(out_port), PULSE_EN ? 32'hFF : 32'h3C);
        rd(2'd3);
        chk("pw_rd", readdata, PULSE_EN ? 32'h8000_00FF : 32'h0);
        wr(2'd0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 1) != 0);
            address    = 2'($urandom);
            writedata  = {16'($urandom_range(0, 6)), 16'($urandom)};
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audioplay_ctrl_out.md
# audioplay_ctrl_out

Avalon-MM slave output port: the write/drive counterpart of the audio player's input PIO filter-select ports. Nios II software writes a registered output word that drives control lines (codec mute, filter enable, LEDs). Atomic set/clear aliases and a hardware-timed one-shot pulse register let software toggle or strobe single lines without read-modify-write races.

## Interface
- WIDTH, 8, output port width, 1..16
- RESET_VALUE, 0, value of the output register after reset
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; one clock domain
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  WIDTH  driven control lines, equal to the DATA register

## Operation
- A write is accepted on any rising edge with chipselect=1 and write_n=0. There are no wait states and no read strobe.
- Address map:
  - 0 DATA, R/W: write sets data <= writedata[WIDTH-1:0] and cancels any active pulse (busy=0, mask=0).
  - 1 OUTSET, W: data <= data | wd. Reads return data.
  - 2 OUTCLEAR, W: data <= data & ~wd. Reads return data.
  - 3 PULSE, R/W: write fields are mask=wd[WIDTH-1:0] and len=wd[31:16]. Effects: data |= mask; pulse_mask |= mask; cnt <= max(len,1); busy <= 1. Reads return {busy at bit31, zeros, pulse_mask at [WIDTH-1:0]}.
- Pulse timer: on each edge with busy=1 and no PULSE write, if cnt==1 then data &= ~pulse_mask, pulse_mask=0, busy=0; otherwise cnt decrements.
- Writing wd bits at or above WIDTH has no effect. Reads of those bits return 0.
- Simultaneous events:
  - PULSE write on the expiry edge: retrigger wins. Masks are ORed, cnt reloads, and no bits clear.
  - OUTSET/OUTCLEAR on the expiry edge: expiry clears first, then the write is applied on top (OUTSET to a masked bit leaves it 1).
  - DATA write always cancels the pulse, including on the expiry edge.
  - OUTSET/OUTCLEAR never change pulse_mask or cnt.
- Reset mid-pulse: all state returns to reset values immediately (asynchronous).

## Timing
- Reset values: out_port=RESET_VALUE, readdata=0, busy=0, pulse_mask=0, cnt=0.
- Write at edge k: out_port reflects the new value after edge k (0-cycle register latency).
- readdata is updated every edge from the current address. Data is valid on the edge after address is presented (1-cycle read latency) and reflects register state before any same-edge write.
- A pulse with len=L≥1 written at edge k holds its bits high from edge k to edge k+L (exactly L cycles). L=0 behaves as L=1.

## Configuration
- AUDIOPLAY_CTRL_OUT_PULSE_EN defined: PULSE register, counter and busy logic are present as specified.
- Not defined: no counter. Writes to address 3 are ignored, reads of address 3 return 0, and busy/pulse_mask are constant 0.

## Structure
- Package audioplay_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_OUTSET=1, ADDR_OUTCLEAR=2, ADDR_PULSE=3
  - BUSY_BIT=31
  - PULSE_LEN_LSB=16, PULSE_CNT_W=16
- Sub-module audioplay_pulse_timer contains the load/retrigger/cancel counter with busy and a one-cycle expire output. It is instantiated only under the macro.

## Test plan
- Reset released with RESET_VALUE=8'h5A -> out_port=8'h5A, readdata=0. Read addr 0 -> readdata=0x5A one cycle later.
- DATA write 0x0F, then OUTSET 0xC0, then OUTCLEAR 0x03 -> out_port goes 0x0F, 0xCF, 0xCC on consecutive edges. Addr 1/2 reads return the current data.
- PULSE write 0x0005_0001 with data=0 -> bit0 high for exactly 5 cycles, busy reads 1 during and 0 after, then out_port=0.
- PULSE len=4 mask 0x01, then at cycle 3 PULSE len=4 mask 0x02 -> both bits clear together 4 cycles after the second write. A DATA write 0x80 mid-pulse -> out_port=0x80 and busy=0.
- OUTSET 0x01 on the expiry edge of a mask=0x01 pulse -> bit0 stays 1. Reset asserted mid-pulse -> out_port=RESET_VALUE immediately and busy=0.
- Macro undefined: PULSE write 0xFFFF_00FF -> out_port unchanged, addr 3 reads 0.
